alu_step_sequencer: RTL and testbench

- Hardwired control-step sequencer that drives the datapath strobes for fetch plus ALU-class instructions (binary, unary, HI/LO-writing).
- Replaces hand-timed T0–T4 strobe sequences with a reusable block.
- Sits between the IR/memory interface and the datapath control inputs.
- Generalised over register count, opcode width and instruction class, with memory-wait and error handling.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/reg_field_decoder.sv | 11 +
 rtl/alu_step_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_step_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states and IR field positions shared by alu_step_sequencer.
package cpu_pkg;
    localparam int OP_W    = 5;
    localparam int RIDX_W  = 4;
    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT = 5'b10010;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6
    } state_e;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return op inside {OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_binary(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return op inside {OP_NEG, OP_NOT};
    endfunction
endpackage

// File: rtl/reg_field_decoder.sv
// reg_field_decoder: 4-bit register index to one-hot select, with an out-of-range flag.
module reg_field_decoder #(
    parameter int REG_COUNT = 16
) (
    input  logic [3:0]           idx_i,
    output logic [REG_COUNT-1:0] onehot_o,
    output logic                 oor_o
);
    assign oor_o    = {28'd0, idx_i} >= 32'(REG_COUNT);
    assign onehot_o = oor_o ? '0 : REG_COUNT'(1) << idx_i;
endmodule

// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: fetch + ALU-class control-step sequencer driving datapath strobes.
// Optional SEQ_SINGLE_STEP_EN adds step_en, gating every transition except IDLE->T0.
module alu_step_sequencer
    import cpu_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int OPCODE_W  = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 step_en,
`endif
    input  logic [DATA_W-1:0]    ir,
    output logic [REG_COUNT-1:0] Rin,
    output logic [REG_COUNT-1:0] Rout,
    output logic                 PCout,
    output logic                 incPC,
    output logic                 PCin,
    output logic                 MARin,
    output logic                 MDRin,
    output logic                 read,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zin,
    output logic                 ZLowOut,
    output logic                 ZHighOut,
    output logic                 HIin,
    output logic                 LOin,
    output logic [OPCODE_W-1:0]  alu_op,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    state_e state_q, state_d;
    logic err_q, err_d, stay_q, adv;
    logic [OP_W-1:0] opcode;
    logic [REG_COUNT-1:0] ra_oh, rb_oh, rc_oh;
    logic ra_oor, rb_oor, rc_oor, bin, md, illegal, unused_ir;

`ifdef SEQ_SINGLE_STEP_EN
    assign adv = step_en;
`else
    assign adv = 1'b1;
`endif

    assign opcode    = ir[OPC_LSB +: OP_W];
    assign unused_ir = ^ir[RC_LSB-1:0];
    assign bin       = is_binary(opcode);
    assign md        = is_muldiv(opcode);
    // Ra is not written by HI/LO ops, Rc is only read by binary ops.
    assign illegal   = !(bin || is_unary(opcode)) || rb_oor || (!md && ra_oor) || (bin && rc_oor);

    reg_field_decoder #(.REG_COUNT(REG_COUNT)) u_ra (.idx_i(ir[RA_LSB +: RIDX_W]), .onehot_o(ra_oh), .oor_o(ra_oor));
    reg_field_decoder #(.REG_COUNT(REG_COUNT)) u_rb (.idx_i(ir[RB_LSB +: RIDX_W]), .onehot_o(rb_oh), .oor_o(rb_oor));
    reg_field_decoder #(.REG_COUNT(REG_COUNT)) u_rc (.idx_i(ir[RC_LSB +: RIDX_W]), .onehot_o(rc_oh), .oor_o(rc_oor));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            stay_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            stay_q  <= state_d == state_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = start ? S_T0 : S_IDLE;
            S_T0:   state_d = adv ? S_T1 : S_T0;
            S_T1:   state_d = (adv && mem_ready) ? S_T2 : S_T1;
            S_T2:   state_d = adv ? S_DEC : S_T2;
            S_DEC:  state_d = !adv ? S_DEC : illegal ? S_IDLE : bin ? S_T3 : S_T4;
            S_T3:   state_d = adv ? S_T4 : S_T3;
            S_T4:   state_d = adv ? S_T5 : S_T4;
            S_T5:   state_d = !adv ? S_T5 : md ? S_T6 : S_IDLE;
            S_T6:   state_d = adv ? S_IDLE : S_T6;
            default: state_d = S_IDLE;
        endcase
        err_d = (state_q == S_IDLE && start) ? 1'b0 : (state_q == S_DEC && illegal) ? 1'b1 : err_q;
    end

    // Moore decode of the state register; stay_q keeps PC updates single-shot per step.
    always_comb begin
        Rin      = '0;
        Rout     = '0;
        PCout    = 1'b0;
        incPC    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        read     = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                incPC = !stay_q;
                Zin   = 1'b1;
            end
            S_T1: begin
                ZLowOut = 1'b1;
                PCin    = !stay_q;
                read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_DEC: done = illegal;
            S_T3: begin
                Rout = rb_oh;
                Yin  = 1'b1;
            end
            S_T4: begin
                alu_op = OPCODE_W'(opcode);
                Zin    = 1'b1;
                Rout   = bin ? rc_oh : rb_oh;
            end
            S_T5: begin
                ZLowOut = 1'b1;
                Rin     = md ? '0 : ra_oh;
                LOin    = md;
                done    = !md;
            end
            S_T6: begin
                ZHighOut = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = state_q != S_IDLE;
    assign err  = err_q || (state_q == S_DEC && illegal);
endmodule

// File: tb/tb_alu_step_sequencer.sv
// tb_alu_step_sequencer: directed + randomized checks against a step-list reference model.
module tb_alu_step_sequencer;
    localparam int RC = 12;
    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
    localparam logic [4:0] MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001, NOT_ = 5'b10010;
    localparam logic [13:0] PCOUT = 14'h2000, INCPC = 14'h1000, PCIN = 14'h0800, MARIN = 14'h0400;
    localparam logic [13:0] MDRIN = 14'h0200, READ = 14'h0100, MDROUT = 14'h0080, IRIN = 14'h0040;
    localparam logic [13:0] YIN = 14'h0020, ZIN = 14'h0010, ZLO = 14'h0008, ZHI = 14'h0004;
    localparam logic [13:0] HIIN = 14'h0002, LOIN = 14'h0001;

    typedef struct packed {
        logic [RC-1:0] rin;
        logic [RC-1:0] rout;
        logic [13:0]   s;
        logic [4:0]    op;
        logic          busy;
        logic          done;
        logic          err;
    } obs_t;

    logic clock = 1'b0, clear = 1'b1, start = 1'b0, mem_ready = 1'b1;
    logic [31:0] ir = '0;
    logic [RC-1:0] Rin, Rout;
    logic PCout, incPC, PCin, MARin, MDRin, read, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0] alu_op;
    logic busy, done, err;
    int tests = 0, failed = 0;
    obs_t exp_q[$];
    logic exp_err_after;

    alu_step_sequencer #(.REG_COUNT(RC), .OPCODE_W(5), .DATA_W(32)) dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready),
`ifdef SEQ_SINGLE_STEP_EN
        .step_en(1'b1),
`endif
        .ir(ir), .Rin(Rin), .Rout(Rout), .PCout(PCout), .incPC(incPC), .PCin(PCin),
        .MARin(MARin), .MDRin(MDRin), .read(read), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
        .alu_op(alu_op), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    function automatic obs_t mk(input logic [RC-1:0] rin, input logic [RC-1:0] rout,
                                input logic [13:0] s, input logic [4:0] op, input logic dn, input logic er);
        return {rin, rout, s, op, 1'b1, dn, er};
    endfunction

    function automatic logic [RC-1:0] oh(input int idx);
        logic [RC-1:0] one = 1;
        return one << idx;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = {Rin, Rout, PCout, incPC, PCin, MARin, MDRin, read, MDRout, IRin, Yin, Zin,
               ZLowOut, ZHighOut, HIin, LOin, alu_op, busy, done, err};
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: list of per-cycle outputs for one instruction, from the step table.
    task automatic build(input logic [31:0] w, input int stalls);
        logic [4:0] op = w[31:27];
        int ra = int'(w[26:23]), rb = int'(w[22:19]), rc = int'(w[18:15]);
        logic md = op inside {MUL, DIV};
        logic bin = md || (op inside {ADD, SUB, AND_, OR_});
        logic un = op inside {NEG, NOT_};
        logic legal = (bin || un) && rb < RC && (md || ra < RC) && (!bin || rc < RC);
        exp_q = {};
        exp_q.push_back(mk('0, '0, PCOUT | MARIN | INCPC | ZIN, '0, 0, 0));
        for (int i = 0; i <= stalls; i++)
            exp_q.push_back(mk('0, '0, ZLO | READ | MDRIN | (i == 0 ? PCIN : 14'h0), '0, 0, 0));
        exp_q.push_back(mk('0, '0, MDROUT | IRIN, '0, 0, 0));
        exp_err_after = !legal;
        if (!legal) begin
            exp_q.push_back(mk('0, '0, '0, '0, 1, 1));
            return;
        end
        exp_q.push_back(mk('0, '0, '0, '0, 0, 0));
        if (bin) exp_q.push_back(mk('0, oh(rb), YIN, '0, 0, 0));
        exp_q.push_back(mk('0, bin ? oh(rc) : oh(rb), ZIN, op, 0, 0));
        exp_q.push_back(mk(md ? '0 : oh(ra), '0, ZLO | (md ? LOIN : 14'h0), '0, !md, 0));
        if (md) exp_q.push_back(mk('0, '0, ZHI | HIIN, '0, 1, 0));
    endtask

    // Entered just after a negedge with the DUT idle; abort_k>0 asserts clear in that cycle.
    task automatic run(input string tag, input logic [31:0] w, input int stalls, input int abort_k);
        build(w, stalls);
        ir = w;
        start = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= exp_q.size(); k++) begin
            check($sformatf("%s c%0d", tag, k), exp_q[k-1]);
            if (k == abort_k) begin
                clear = 1'b1;
                #1 check({tag, " async clear"}, '0);
                @(negedge clock);
                clear = 1'b0;
                start = 1'b0;
                check({tag, " idle after clear"}, '0);
                return;
            end
            start = 1'($urandom);
            mem_ready = (k >= 2 && k <= stalls + 2) ? (k >= stalls + 2) : 1'($urandom);
            @(negedge clock);
        end
        start = 1'b0;
        check({tag, " idle"}, {{(2*RC+19){1'b0}}, exp_err_after});
        @(negedge clock);
        check({tag, " idle2"}, {{(2*RC+19){1'b0}}, exp_err_after});
    endtask

    initial begin
        logic [4:0] ops [9] = '{ADD, SUB, AND_, OR_, MUL, DIV, NEG, NOT_, 5'b11111};
        #1 check("reset", '0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
        check("reset release", '0);
        @(negedge clock);
        run("add", {ADD, 4'd4, 4'd3, 4'd7, 15'd0}, 0, 0);
        run("neg", {NEG, 4'd5, 4'd0, 4'd9, 15'd0}, 0, 0);
        run("mul", {MUL, 4'd15, 4'd2, 4'd6, 15'd0}, 0, 0);
        run("stall", {SUB, 4'd1, 4'd2, 4'd3, 15'd0}, 3, 0);
        run("illegal", {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0);
        run("err clr", {NOT_, 4'd6, 4'd6, 4'd0, 15'd0}, 1, 0);
        run("clear t4", {ADD, 4'd4, 4'd3, 4'd7, 15'd0}, 0, 6);
        run("after clr", {DIV, 4'd0, 4'd11, 4'd10, 15'd0}, 0, 0);
        run("rc oor", {OR_, 4'd2, 4'd11, 4'd12, 15'd0}, 0, 0);
        run("ra oor", {NEG, 4'd12, 4'd3, 4'd0, 15'd0}, 0, 0);
        run("ra=rb", {AND_, 4'd11, 4'd11, 4'd0, 15'd0}, 2, 0);
        for (int n = 0; n < 40; n++) begin
            int sel = $urandom_range(0, 9);
            logic [4:0] op = (sel == 9) ? 5'($urandom) : ops[sel];
            run($sformatf("rnd%0d", n), {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)},
                $urandom_range(0, 3), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
